// File: rtl/uart_core_if.sv
// uart_core_if: peripheral-side bus of the UART core.
//   rx_data   8  last correctly framed received byte
//   rx_status 1  one-cycle pulse, rx_data has just been updated
//   rx_error  1  one-cycle pulse, stop bit sampled low, byte dropped
//   tx_data   8  byte to send, sampled on the accept cycle only
//   tx_en     1  transmit request (level)
//   tx_status 1  transmitter idle and able to accept
//
// Handshake: tx_en is "valid" and tx_status is "ready"; a byte transfers on
// every sysclk rising edge where both are 1. tx_en is level sensitive, so
// holding it high sends frames back to back. rx_status is valid-only: there
// is no backpressure, the peripheral must latch rx_data in that cycle.
interface uart_core_if;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       rx_error;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_status;

  modport master (
    output tx_data, tx_en,
    input  rx_data, rx_status, rx_error, tx_status
  );

  modport slave (
    input  tx_data, tx_en,
    output rx_data, rx_status, rx_error, tx_status
  );
endinterface

// File: rtl/uart_core.sv
// uart_core: single-clock 8N1 UART with a free-running 16x baud-tick
// generator, a receiver and a transmitter (full duplex).
//   sysclk     in   system clock, everything on its rising edge
//   reset      in   synchronous, active-low reset
//   uart_rx    in   serial input, idle high, asynchronous to sysclk
//   uart_tx    out  serial output, idle high
//   baud_tick  out  one-cycle 16x-baud enable (debug)
//   rx_state   out  receiver FSM state (debug)
//   tx_state   out  transmitter FSM state (debug)
//   bus        slave side of uart_core_if (rx_data/status/error, tx_*)
module uart_core #(
  parameter int DIV        = 651,
  parameter int OVERSAMPLE = 16
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        baud_tick,
  output logic [1:0]  rx_state,
  output logic        tx_state,
  uart_core_if.slave  bus
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [3:0]    LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]    MID_TICK  = 4'(OVERSAMPLE / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic TX_IDLE = 1'b0;
  localparam logic TX_BUSY = 1'b1;

  // ---------------- tick generator (never restarted by RX/TX) -------------
  logic [CW-1:0] div_cnt;

  always_ff @(posedge sysclk) begin
    if (!reset) div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else div_cnt <= div_cnt + 1'b1;
  end

  assign baud_tick = (div_cnt == DIV_LAST);

  // ---------------- receiver ----------------------------------------------
  logic       rx_meta, rx_s;
  logic [3:0] rx_tick;
  logic [2:0] rx_idx;
  logic [7:0] rx_shift;

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      rx_state      <= RX_IDLE;
      rx_tick       <= '0;
      rx_idx        <= '0;
      rx_shift      <= '0;
      bus.rx_data   <= '0;
      bus.rx_status <= 1'b0;
      bus.rx_error  <= 1'b0;
    end else begin
      rx_meta       <= uart_rx;
      rx_s          <= rx_meta;
      bus.rx_status <= 1'b0;
      bus.rx_error  <= 1'b0;
      if (baud_tick) begin
        case (rx_state)
          RX_IDLE: begin
            if (!rx_s) begin
              rx_state <= RX_START;
              rx_tick  <= '0;
            end
          end
          RX_START: begin
            // Re-check the line mid start bit to reject glitches.
            if (rx_tick == MID_TICK) begin
              rx_tick <= '0;
              rx_idx  <= '0;
              rx_state <= rx_s ? RX_IDLE : RX_DATA;
            end else begin
              rx_tick <= rx_tick + 1'b1;
            end
          end
          RX_DATA: begin
            if (rx_tick == LAST_TICK) begin
              rx_tick  <= '0;
              // LSB arrives first, so shift in from the top.
              rx_shift <= {rx_s, rx_shift[7:1]};
              if (rx_idx == 3'd7) rx_state <= RX_STOP;
              else rx_idx <= rx_idx + 1'b1;
            end else begin
              rx_tick <= rx_tick + 1'b1;
            end
          end
          RX_STOP: begin
            // Leave mid stop bit so a following start edge is not missed.
            if (rx_tick == LAST_TICK) begin
              rx_tick  <= '0;
              rx_state <= RX_IDLE;
              if (rx_s) begin
                bus.rx_data   <= rx_shift;
                bus.rx_status <= 1'b1;
              end else begin
                bus.rx_error  <= 1'b1;
              end
            end else begin
              rx_tick <= rx_tick + 1'b1;
            end
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  // ---------------- transmitter -------------------------------------------
  // The start bit goes out on the accept edge; every bit then lasts 16
  // ticks counted from accept, regardless of the divider phase.
  logic [8:0] tx_frame;   // {stop, d7..d0}, shifted out LSB first
  logic [3:0] tx_tick;
  logic [3:0] tx_bit;     // 0 = start, 1..8 = data, 9 = stop

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      tx_state      <= TX_IDLE;
      uart_tx       <= 1'b1;
      bus.tx_status <= 1'b1;
      tx_frame      <= '0;
      tx_tick       <= '0;
      tx_bit        <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (bus.tx_en) begin
            tx_frame      <= {1'b1, bus.tx_data};
            uart_tx       <= 1'b0;
            bus.tx_status <= 1'b0;
            tx_tick       <= '0;
            tx_bit        <= '0;
            tx_state      <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (baud_tick) begin
            if (tx_tick == LAST_TICK) begin
              tx_tick <= '0;
              if (tx_bit == 4'd9) begin
                tx_state      <= TX_IDLE;
                bus.tx_status <= 1'b1;
              end else begin
                uart_tx  <= tx_frame[0];
                tx_frame <= {1'b0, tx_frame[8:1]};
                tx_bit   <= tx_bit + 1'b1;
              end
            end else begin
              tx_tick <= tx_tick + 1'b1;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core.sv
module tb_uart_core;
  localparam int DIV = 4;
  localparam int BIT = 64;   // sysclk cycles per bit with DIV=4

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic       uart_rx;
  logic       uart_tx;
  logic       baud_tick;
  logic [1:0] rx_state;
  logic       tx_state;
  logic       rx_drv   = 1'b1;
  logic       loopback = 1'b0;

  assign uart_rx = loopback ? uart_tx : rx_drv;

  uart_core_if bus();

  uart_core #(.DIV(DIV)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx),
    .baud_tick (baud_tick),
    .rx_state  (rx_state),
    .tx_state  (tx_state),
    .bus       (bus)
  );

  // ---------------- clock ----------------
  always #5 sysclk = ~sysclk;

  // ---------------- scoreboard state ----------------
  int         n_checks   = 0;
  int         n_fail     = 0;
  int         status_cnt = 0;
  int         error_cnt  = 0;
  logic       prev_status = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_err;
  } rx_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Receive monitor: every rx_status pops one expected byte.
  always @(negedge sysclk) begin
    if (reset) begin
      if (bus.rx_status) begin
        status_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_unexpected: got byte 0x%0h, expected no byte", bus.rx_data);
        end else begin
          check("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
        end
        if (prev_status) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_status_width: got pulse longer than 1 cycle, expected 1");
        end
      end
      if (bus.rx_error) error_cnt++;
      prev_status = bus.rx_status;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop, input int gap);
    rx_drv = 1'b0;
    cycles(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      cycles(BIT);
    end
    rx_drv = stop;
    cycles(BIT);
    rx_drv = 1'b1;
    cycles(gap);
  endtask

  task automatic wait_status(input logic val, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sysclk);
      if (bus.tx_status === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Samples uart_tx mid-bit from the first busy cycle; dur = busy cycles.
  task automatic capture_tx(output logic [9:0] bits, output int dur, output logic ok);
    logic got;
    bits = '0;
    dur  = 0;
    wait_status(1'b0, 200, got);
    ok = got;
    if (!got) return;
    dur = 1;
    while (bus.tx_status === 1'b0 && dur < 800) begin
      if (dur >= 32 && dur <= 32 + 64 * 9 && ((dur - 32) % 64) == 0)
        bits[(dur - 32) / 64] = uart_tx;
      @(negedge sysclk);
      dur++;
    end
    ok  = (bus.tx_status === 1'b1);
    dur = dur - 1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  rx_vec_t vecs[7];

  initial begin
    logic [9:0] bits;
    int         dur;
    logic       ok;
    int         s0, e0, last_tick, ticks;
    logic       idle_ok;
    logic [7:0] last_good;
    logic [7:0] rnd;

    vecs[0] = '{8'h0F, 1'b1, 8'h0F, 1'b0};
    vecs[1] = '{8'hA5, 1'b0, 8'h0F, 1'b1};
    vecs[2] = '{8'h3C, 1'b1, 8'h3C, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    vecs[5] = '{8'h81, 1'b0, 8'hFF, 1'b1};
    vecs[6] = '{8'h5A, 1'b1, 8'h5A, 1'b0};

    bus.tx_en   = 1'b0;
    bus.tx_data = 8'h00;

    // Reset held for 3 cycles.
    reset = 1'b0;
    cycles(3);
    check("reset_uart_tx",   {31'd0, uart_tx},        32'd1);
    check("reset_tx_status", {31'd0, bus.tx_status},  32'd1);
    check("reset_rx_data",   {24'd0, bus.rx_data},    32'd0);
    check("reset_rx_status", {31'd0, bus.rx_status},  32'd0);
    check("reset_rx_error",  {31'd0, bus.rx_error},   32'd0);
    check("reset_baud_tick", {31'd0, baud_tick},      32'd0);
    check("reset_rx_state",  {30'd0, rx_state},       32'd0);
    check("reset_tx_state",  {31'd0, tx_state},       32'd0);

    // Baud tick every 4th cycle after release.
    reset = 1'b1;
    last_tick = -1;
    ticks = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge sysclk);
      if (baud_tick) begin
        if (last_tick >= 0) check("baud_tick_period", c - last_tick, 32'd4);
        last_tick = c;
        ticks++;
      end
    end
    check("baud_tick_count", ticks, 32'd10);
    cycles(13);

    // Table-driven receive frames, including bad stop bits.
    last_good = 8'h00;
    for (int i = 0; i < 7; i++) begin
      s0 = status_cnt;
      e0 = error_cnt;
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_rx(vecs[i].data, vecs[i].stop, BIT);
      check("rx_vec_data",   {24'd0, bus.rx_data},     {24'd0, vecs[i].exp_data});
      check("rx_vec_error",  error_cnt - e0,           {31'd0, vecs[i].exp_err});
      check("rx_vec_status", status_cnt - s0,          {31'd0, ~vecs[i].exp_err});
      if (vecs[i].stop) last_good = vecs[i].data;
    end

    // Random valid frames.
    for (int i = 0; i < 4; i++) begin
      rnd = 8'($urandom_range(0, 255));
      s0 = status_cnt;
      exp_q.push_back(rnd);
      send_rx(rnd, 1'b1, BIT);
      last_good = rnd;
      check("rx_rand_status", status_cnt - s0, 32'd1);
      check("rx_rand_data", {24'd0, bus.rx_data}, {24'd0, last_good});
    end

    // Glitch shorter than half a bit: false start, nothing reported.
    s0 = status_cnt;
    e0 = error_cnt;
    rx_drv = 1'b0;
    cycles(20);
    rx_drv = 1'b1;
    cycles(200);
    check("glitch_status", status_cnt - s0, 32'd0);
    check("glitch_error",  error_cnt - e0,  32'd0);
    check("glitch_rx_idle", {30'd0, rx_state}, 32'd0);
    check("glitch_rx_data", {24'd0, bus.rx_data}, {24'd0, last_good});

    // Transmit 0x0F with tx_en held for 21 cycles: exactly one frame.
    bus.tx_data = 8'h0F;
    bus.tx_en   = 1'b1;
    fork
      begin
        cycles(21);
        bus.tx_en   = 1'b0;
        bus.tx_data = 8'hFF;
      end
      capture_tx(bits, dur, ok);
    join
    check("tx_frame_done", {31'd0, ok}, 32'd1);
    check("tx_start_bit", {31'd0, bits[0]}, 32'd0);
    check("tx_data_bits", {24'd0, bits[8:1]}, 32'h0F);
    check("tx_stop_bit", {31'd0, bits[9]}, 32'd1);
    check("tx_busy_len_in_range", {31'd0, (dur >= 636 && dur <= 644)}, 32'd1);
    idle_ok = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge sysclk);
      if (bus.tx_status !== 1'b1 || uart_tx !== 1'b1) idle_ok = 1'b0;
    end
    check("tx_single_frame", {31'd0, idle_ok}, 32'd1);

    // Loopback: 0x55 then 0xAA back to back with tx_en held.
    loopback = 1'b1;
    cycles(4);
    s0 = status_cnt;
    bus.tx_data = 8'h55;
    bus.tx_en   = 1'b1;
    exp_q.push_back(8'h55);
    wait_status(1'b0, 20, ok);
    check("loop_accept_1", {31'd0, ok}, 32'd1);
    bus.tx_data = 8'hAA;   // change while busy must not disturb frame 1
    exp_q.push_back(8'hAA);
    wait_status(1'b1, 800, ok);
    check("loop_done_1", {31'd0, ok}, 32'd1);
    wait_status(1'b0, 4, ok);
    check("loop_accept_2", {31'd0, ok}, 32'd1);
    bus.tx_en = 1'b0;
    wait_status(1'b1, 800, ok);
    check("loop_done_2", {31'd0, ok}, 32'd1);
    cycles(100);
    check("loop_rx_count", status_cnt - s0, 32'd2);
    check("loop_rx_last", {24'd0, bus.rx_data}, 32'hAA);
    loopback = 1'b0;

    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
